// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the scoreboarded register file
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    typedef enum logic {
        SWEEP_IDLE,
        SWEEP_RUN
    } sweep_state_e;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// rtl/regfile_sweep_ctrl.sv - sequential sweep-clear FSM and index counter
import regfile_pkg::*;

module regfile_sweep_ctrl #(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    sweep_state_e      state, state_nxt;
    logic [ADDR_W-1:0] idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SWEEP_IDLE;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = sweep_idx;
        clr_busy  = 1'b0;
        sweep_en  = 1'b0;
        case (state)
            SWEEP_IDLE: begin
                if (clr_req) begin
                    state_nxt = SWEEP_RUN;
                    idx_nxt   = '0;
                end
            end
            SWEEP_RUN: begin
                clr_busy = 1'b1;
                sweep_en = 1'b1;
                idx_nxt  = sweep_idx + 1'b1;
                // the last index is cleared on the same edge that returns to idle
                if (sweep_idx == LAST_IDX) begin
                    state_nxt = SWEEP_IDLE;
                end
            end
            default: state_nxt = SWEEP_IDLE;
        endcase
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read register file with write bypass, busy scoreboard and sweep clear
import regfile_pkg::*;

module regfile_sb #(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    alloc_en,
    input  logic [ADDR_W-1:0]       alloc_addr,
    input  logic                    clr_req,
    output logic                    clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_idx;
    logic              wr_ok;
    logic              alloc_ok;

    regfile_sweep_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .sweep_en  (sweep_en),
        .sweep_idx (sweep_idx)
    );

    assign wr_ok    = wr_en && !sweep_en && ((ZERO_REG == 0) || (wr_addr != '0));
    assign alloc_ok = alloc_en && !sweep_en && ((ZERO_REG == 0) || (alloc_addr != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else if (sweep_en) begin
            mem[sweep_idx]  <= '0;
            busy[sweep_idx] <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_addr]  <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // alloc is applied last so a newly issued producer keeps the register busy
            if (alloc_ok) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
            bsy  = busy[addr];
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end else if (wr_en && !sweep_en && (addr == wr_addr)) begin
                data = wr_data;
                bsy  = 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p]                  = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [63:0] rd_data_nz;
    logic [1:0]  rd_busy_nz;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_busy_nz;

    int pass_cnt;
    int check_cnt;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0)) dut_nz (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_nz),
        .rd_busy    (rd_busy_nz),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            check_cnt++;
            if ({rd_data, rd_busy} !== 66'd0) begin
                $display("FAIL reset_read addr %0d: got data %h busy %b, expected 0", a, rd_data, rd_busy);
            end else pass_cnt++;
        end
        check_cnt++;
        if (clr_busy !== 1'b0) $display("FAIL reset_clr_busy: got %b expected 0", clr_busy);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        #1;
        check_cnt++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0)
            $display("FAIL bypass_same_cycle: got %h/%b expected deadbeef/0", rd_data[31:0], rd_busy[0]);
        else pass_cnt++;
        tick();
        wr_en = 1'b0;
        #1;
        check_cnt++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0)
            $display("FAIL bypass_stored: got %h/%b expected deadbeef/0", rd_data[31:0], rd_busy[0]);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        alloc_en = 1'b1; alloc_addr = 5'd7;
        rd_addr = {5'd7, 5'd7};
        #1;
        check_cnt++;
        if (rd_busy !== 2'b00) $display("FAIL alloc_not_bypassed: got %b expected 00", rd_busy);
        else pass_cnt++;
        tick();
        alloc_en = 1'b0;
        #1;
        check_cnt++;
        if (rd_busy !== 2'b11) $display("FAIL alloc_busy: got %b expected 11", rd_busy);
        else pass_cnt++;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
        #1;
        check_cnt++;
        if (rd_data[31:0] !== 32'h0000_1234 || rd_busy[0] !== 1'b0)
            $display("FAIL wb_bypass_busy: got %h/%b expected 00001234/0", rd_data[31:0], rd_busy[0]);
        else pass_cnt++;
        tick();
        wr_en = 1'b0;
        #1;
        check_cnt++;
        if (rd_data[63:32] !== 32'h0000_1234 || rd_busy[1] !== 1'b0)
            $display("FAIL wb_clears_busy: got %h/%b expected 00001234/0", rd_data[63:32], rd_busy[1]);
        else pass_cnt++;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        alloc_en = 1'b1; alloc_addr = 5'd9;
        rd_addr = {5'd9, 5'd9};
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        check_cnt++;
        if (rd_data[31:0] !== 32'h55 || rd_busy[0] !== 1'b1)
            $display("FAIL alloc_wins: got %h/%b expected 00000055/1", rd_data[31:0], rd_busy[0]);
        else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        check_cnt++;
        if (rd_data[63:32] !== 32'd0 || rd_busy[1] !== 1'b0)
            $display("FAIL zero_reg_bypass: got %h/%b expected 00000000/0", rd_data[63:32], rd_busy[1]);
        else pass_cnt++;
        check_cnt++;
        if (rd_data_nz[63:32] !== 32'hFFFFFFFF || rd_busy_nz[1] !== 1'b0)
            $display("FAIL nz_reg0_bypass: got %h/%b expected ffffffff/0", rd_data_nz[63:32], rd_busy_nz[1]);
        else pass_cnt++;
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        check_cnt++;
        if (rd_data[63:32] !== 32'd0 || rd_busy[1] !== 1'b0)
            $display("FAIL zero_reg_stored: got %h/%b expected 00000000/0", rd_data[63:32], rd_busy[1]);
        else pass_cnt++;
        check_cnt++;
        if (rd_data_nz[63:32] !== 32'hFFFFFFFF || rd_busy_nz[1] !== 1'b1)
            $display("FAIL nz_reg0_stored: got %h/%b expected ffffffff/1", rd_data_nz[63:32], rd_busy_nz[1]);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        int cnt;
        for (int a = 1; a < 32; a++) begin
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'hA5A5A5A5;
            tick();
        end
        wr_en = 1'b0;
        alloc_en = 1'b1; alloc_addr = 5'd3;
        tick();
        alloc_en = 1'b0;
        rd_addr = {5'd31, 5'd3};
        #1;
        check_cnt++;
        if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b1 || rd_data[63:32] !== 32'hA5A5A5A5)
            $display("FAIL fill: got %h/%b %h expected a5a5a5a5/1 a5a5a5a5", rd_data[31:0], rd_busy[0], rd_data[63:32]);
        else pass_cnt++;
        clr_req = 1'b1;
        #1;
        check_cnt++;
        if (clr_busy !== 1'b0) $display("FAIL clr_busy_before_edge: got %b expected 0", clr_busy);
        else pass_cnt++;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 20) begin
                // index 19 is next; 0..18 are already cleared, 25 is not yet
                wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0BAD_0BAD;
                clr_req = 1'b1;
                rd_addr = {5'd25, 5'd10};
                #1;
                check_cnt++;
                if (rd_data[31:0] !== 32'd0)
                    $display("FAIL sweep_no_bypass: got %h expected 00000000", rd_data[31:0]);
                else pass_cnt++;
                check_cnt++;
                if (rd_data[63:32] !== 32'hA5A5A5A5)
                    $display("FAIL sweep_partial: got %h expected a5a5a5a5", rd_data[63:32]);
                else pass_cnt++;
            end
            tick();
            wr_en = 1'b0;
            clr_req = 1'b0;
        end
        check_cnt++;
        if (cnt != 32) $display("FAIL clr_busy_cycles: got %0d expected 32", cnt);
        else pass_cnt++;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            check_cnt++;
            if (rd_data[31:0] !== 32'd0 || rd_busy[0] !== 1'b0 || rd_data_nz[31:0] !== 32'd0 || rd_busy_nz[0] !== 1'b0)
                $display("FAIL post_sweep addr %0d: got %h/%b nz %h/%b expected 0/0", a, rd_data[31:0], rd_busy[0], rd_data_nz[31:0], rd_busy_nz[0]);
            else pass_cnt++;
        end
        tick();
        check_cnt++;
        if (clr_busy !== 1'b0) $display("FAIL post_sweep_clr_busy: got %b expected 0", clr_busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h0000_0011;
        alloc_en = 1'b1; alloc_addr = 5'd25;
        tick();
        wr_en = 1'b0; alloc_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check_cnt++;
        if (clr_busy !== 1'b1) $display("FAIL mid_sweep_start: got %b expected 1", clr_busy);
        else pass_cnt++;
        repeat (11) tick();
        rd_addr = {5'd25, 5'd20};
        #1;
        check_cnt++;
        if (rd_data[31:0] !== 32'h11 || rd_busy[1] !== 1'b1)
            $display("FAIL mid_sweep_uncleared: got %h/%b expected 00000011/1", rd_data[31:0], rd_busy[1]);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (clr_busy !== 1'b0) $display("FAIL mid_sweep_reset_abort: got %b expected 0", clr_busy);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            check_cnt++;
            if ({rd_data, rd_busy} !== 66'd0)
                $display("FAIL mid_sweep_reset_read addr %0d: got data %h busy %b, expected 0", a, rd_data, rd_busy);
            else pass_cnt++;
        end
        tick();
        check_cnt++;
        if (clr_busy !== 1'b0) $display("FAIL mid_sweep_after_release: got %b expected 0", clr_busy);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        check_cnt  = 0;
        rst_n      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        clr_req    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_sweep();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
